// File: rtl/serial_sorter_if.sv
// Valid/ready stream bundle for serial_sorter: one input stream and one
// sorted output stream with an end-of-frame marker.
interface serial_sorter_if #(
    parameter int DW = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/serial_sorter.sv
// Streaming frame sorter: loads N words, runs N odd-even transposition passes
// in place, then drains the frame smallest-first with an end-of-frame flag.
module serial_sorter #(
    parameter int N  = 8,
    parameter int DW = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_sorter_if.slave stream,
    output logic           busy
);
    localparam int              CW        = $clog2(N + 1);
    localparam int              IW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST_IDX  = CW'(N - 1);
    localparam logic [CW-1:0]   SORT_DONE = CW'(N);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        UNLOAD
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mem_q  [N];
    logic [DW-1:0] mem_d  [N];
    logic [DW-1:0] pass_d [N];
    logic [IW-1:0] idx;

    assign idx = cnt_q[IW-1:0];

    // One transposition pass; pairs never overlap, so every compare reads mem_q.
    always_comb begin
        pass_d = mem_q;
        for (int j = 0; j < N - 1; j++) begin
            if (((j % 2) == 1) == cnt_q[0] && mem_q[j] > mem_q[j+1]) begin
                pass_d[j]   = mem_q[j+1];
                pass_d[j+1] = mem_q[j];
            end
        end
    end

    // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        unique case (state_q)
            LOAD: begin
                if (stream.in_valid) begin
                    mem_d[idx] = stream.in_data;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = SORT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            // cnt reaching N is an idle turn that lines up the output latency.
            SORT: begin
                if (cnt_q == SORT_DONE) begin
                    cnt_d   = '0;
                    state_d = UNLOAD;
                end else begin
                    mem_d = pass_d;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UNLOAD: begin
                if (stream.out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: the frame buffer is reset along with the control so a cleared block presents all-zero storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            mem_q   <= '{default: '0};
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    assign stream.in_ready  = (state_q == LOAD);
    assign stream.out_valid = (state_q == UNLOAD);
    assign stream.out_data  = (state_q == UNLOAD) ? mem_q[idx] : '0;
    assign stream.out_last  = (state_q == UNLOAD) && (cnt_q == LAST_IDX);
    assign busy             = (state_q != LOAD);

endmodule

// File: tb/tb_serial_sorter.sv
// Directed scoreboard bench for serial_sorter: sorted expectations are queued
// as each frame is driven and popped as the sorter emits words.
module tb_serial_sorter;
    localparam int N  = 8;
    localparam int DW = 7;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   fr [N];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sorter_if #(.DW(DW)) bus ();

    serial_sorter #(.N(N), .DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .stream (bus),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        int s [N];
        exp_t e;
        s = fr;
        for (int i = 1; i < N; i++) begin
            int key;
            int j;
            key = s[i];
            j   = i - 1;
            while (j >= 0 && s[j] > key) begin
                s[j+1] = s[j];
                j--;
            end
            s[j+1] = key;
        end
        for (int i = 0; i < N; i++) begin
            e.data = DW'(s[i]);
            e.last = (i == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the last accept.
    task automatic send_frame(input int gap, output int first_cyc);
        first_cyc = 0;
        push_expected();
        for (int i = 0; i < N; i++) begin
            repeat (gap) begin
                bus.in_valid = 1'b0;
                bus.in_data  = DW'($urandom);
                @(negedge clk);
                check("busy_in_gap", busy, 0);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(fr[i]);
            check("in_ready_load", bus.in_ready, 1);
            @(negedge clk);
            if (i == 0) first_cyc = cyc;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = DW'($urandom);
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        check("busy_sort", busy, 1);
        check("in_ready_sort", bus.in_ready, 0);
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, N + 1);
    endtask

    task automatic drain(input bit toggle, input int max_words);
        int            words;
        int            j;
        bit            stalled;
        bit            done;
        logic [DW-1:0] held_d;
        logic          held_l;
        exp_t          e;
        words   = 0;
        j       = 0;
        stalled = 1'b0;
        done    = 1'b0;
        held_d  = '0;
        held_l  = 1'b0;
        while (!done && j < 200) begin
            bus.out_ready = toggle ? ((j % 2) == 0) : 1'b1;
            if (stalled) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, held_d);
                check("hold_last", bus.out_last, held_l);
            end
            stalled = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_underflow", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", bus.out_data, e.data);
                        check("out_last", bus.out_last, e.last);
                    end
                    words++;
                    if (bus.out_last || words == max_words) done = 1'b1;
                end else begin
                    stalled = 1'b1;
                    held_d  = bus.out_data;
                    held_l  = bus.out_last;
                end
            end else if (words > 0) begin
                check("out_continuous", bus.out_valid, 1);
            end
            @(negedge clk);
            j++;
        end
        bus.out_ready = 1'b0;
        check("drain_done", done, 1);
    endtask

    task automatic run_frame(input int gap, input bit toggle);
        int c;
        send_frame(gap, c);
        wait_out();
        drain(toggle, N);
        check("in_ready_turnaround", bus.in_ready, 1);
        check("out_valid_after", bus.out_valid, 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int c1;
        int c2;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_data", bus.out_data, 0);
        check("reset_out_last", bus.out_last, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        fr = '{5, 3, 7, 1, 6, 2, 4, 0};
        run_frame(0, 1'b0);
        fr = '{127, 126, 125, 124, 123, 122, 121, 120};
        run_frame(0, 1'b0);
        fr = '{10, 20, 30, 40, 50, 60, 70, 80};
        run_frame(0, 1'b0);
        fr = '{42, 42, 42, 42, 42, 42, 42, 42};
        run_frame(0, 1'b0);
        fr = '{3, 1, 3, 0, 1, 127, 0, 3};
        run_frame(0, 1'b0);

        fr = '{10, 50, 3, 99, 3, 0, 77, 20};
        run_frame(2, 1'b0);
        fr = '{64, 1, 100, 33, 33, 8, 127, 0};
        run_frame(0, 1'b1);

        fr = '{100, 90, 80, 70, 60, 50, 40, 30};
        send_frame(0, c1);
        repeat (3) @(negedge clk);
        pulse_reset();

        fr = '{111, 5, 99, 17, 64, 2, 88, 40};
        send_frame(0, c1);
        wait_out();
        drain(1'b0, 3);
        pulse_reset();
        check("no_residue_valid", bus.out_valid, 0);

        fr = '{9, 8, 7, 6, 5, 4, 3, 2};
        run_frame(0, 1'b0);

        fr = '{7, 6, 5, 4, 3, 2, 1, 0};
        send_frame(0, c1);
        wait_out();
        drain(1'b0, N);
        fr = '{0, 0, 0, 0, 127, 127, 127, 127};
        send_frame(0, c2);
        check("frame_period_ge17", ((c2 - c1) >= 17), 1);
        wait_out();
        drain(1'b0, N);
        check("b2b_scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
